// File: rtl/matrix_to_sevenseg_pkg.sv
// Shared definitions for the LED-matrix to seven-segment decoder: geometry,
// segment indices, the segment-to-pixel map and the capture FSM state type.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef struct packed {
    logic [2:0] row;
    logic [1:0] col;
  } pix_t;

  // Two pixels per segment, indexed [segment][pixel]
  localparam pix_t SEG_PIX [7][2] = '{
    '{'{3'd0, 2'd1}, '{3'd0, 2'd2}},
    '{'{3'd1, 2'd3}, '{3'd2, 2'd3}},
    '{'{3'd4, 2'd3}, '{3'd5, 2'd3}},
    '{'{3'd6, 2'd1}, '{3'd6, 2'd2}},
    '{'{3'd4, 2'd0}, '{3'd5, 2'd0}},
    '{'{3'd1, 2'd0}, '{3'd2, 2'd0}},
    '{'{3'd3, 2'd1}, '{3'd3, 2'd2}}
  };

  typedef enum logic [1:0] {
    ST_WAIT_COL = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_HOLD     = 2'd2,
    ST_EMIT     = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_to_sevenseg_if.sv
// Matrix-side inputs and decoded seven-segment outputs of matrix_to_sevenseg.
interface matrix_to_sevenseg_if;
  logic [7:0] io_out;
  logic [3:0] io_col;
  logic [7:0] sevenseg_out;
  logic       frame_valid;
  logic       frame_error;
  logic       stale;

  modport master (output io_out, io_col, input sevenseg_out, frame_valid, frame_error, stale);
  modport slave  (input io_out, io_col, output sevenseg_out, frame_valid, frame_error, stale);
endinterface

// File: rtl/matrix_to_sevenseg_decode.sv
// Combinational map of one captured 8x4 frame (1 = lit) to active-low
// segments plus a malformed-frame flag.
module matrix_frame_decode
  import matrix_pkg::*;
(
  input  logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] frame,
  output logic [6:0]                              seg,
  output logic                                    error
);

  logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] used_s;
  logic                                    partial_s;
  logic                                    p0_s;
  logic                                    p1_s;

  // Segment decode; a lone lit pixel of a pair or any unmapped pixel is an error
  always_comb begin
    used_s    = '0;
    seg       = 7'h7F;
    partial_s = 1'b0;
    p0_s      = 1'b0;
    p1_s      = 1'b0;
    for (int s = 0; s < 7; s++) begin
      p0_s = frame[SEG_PIX[s][0].col][SEG_PIX[s][0].row];
      p1_s = frame[SEG_PIX[s][1].col][SEG_PIX[s][1].row];
      seg[s] = ~(p0_s & p1_s);
      partial_s = partial_s | (p0_s ^ p1_s);
      used_s[SEG_PIX[s][0].col][SEG_PIX[s][0].row] = 1'b1;
      used_s[SEG_PIX[s][1].col][SEG_PIX[s][1].row] = 1'b1;
    end
    error = partial_s | (|(frame & ~used_s));
  end

endmodule

// File: rtl/matrix_to_sevenseg.sv
// Receives a strobed 8x4 active-low LED matrix scan, captures each column once
// it has settled and turns every complete four-column frame into a segment byte.
module matrix_to_sevenseg
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int TIMEOUT     = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_to_sevenseg_if.slave  mif
);

  localparam int LIMIT = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT);

  logic [7:0] row_sync_s;
  logic [3:0] col_sync_s;
  logic [7:0] lit_s;
  logic       col_valid_s;
  logic [1:0] col_idx_s;

  state_t                                  state_r, state_nxt_s;
  logic [1:0]                              col_r;
  logic [7:0]                              row_ref_r;
  logic [CNT_W-1:0]                        settle_cnt_r;
  logic [CNT_W-1:0]                        tmo_cnt_r;
  logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] frame_buf_r;
  logic [3:0]                              seen_r;
  logic [3:0]                              seen_nxt_s;
  logic                                    tmo_hit_s, capture_s, frame_done_s, restart_s;
  logic [6:0]                              seg_dec_s;
  logic                                    err_dec_s;
  logic [7:0]                              seg_r, seg_nxt_s;
  logic                                    fv_r, fv_nxt_s, err_r, err_nxt_s, stale_r, stale_nxt_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign row_sync_s = mif.io_out;
      assign col_sync_s = mif.io_col;
    end else begin : g_sync
      logic [7:0] row_pipe_r [SYNC_STAGES];
      logic [3:0] col_pipe_r [SYNC_STAGES];
      // Synchronizer chain, idles at the "nothing strobed" level
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            row_pipe_r[i] <= 8'hFF;
            col_pipe_r[i] <= 4'hF;
          end
        end else begin
          row_pipe_r[0] <= mif.io_out;
          col_pipe_r[0] <= mif.io_col;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            row_pipe_r[i] <= row_pipe_r[i-1];
            col_pipe_r[i] <= col_pipe_r[i-1];
          end
        end
      end
      assign row_sync_s = row_pipe_r[SYNC_STAGES-1];
      assign col_sync_s = col_pipe_r[SYNC_STAGES-1];
    end
  endgenerate

  assign lit_s = ~row_sync_s;

  // One-cold strobe to column index
  always_comb begin
    col_valid_s = 1'b1;
    col_idx_s   = 2'd0;
    case (col_sync_s)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_valid_s = 1'b0;
    endcase
  end

  assign tmo_hit_s    = (tmo_cnt_r == TIMEOUT_LAST);
  assign capture_s    = (state_r == ST_SETTLE) && col_valid_s && (col_idx_s == col_r) &&
                        (lit_s == row_ref_r) && (settle_cnt_r == SETTLE_LAST) && !tmo_hit_s;
  assign seen_nxt_s   = seen_r | (4'b0001 << col_r);
  assign frame_done_s = capture_s && (seen_nxt_s == 4'hF);
  assign restart_s    = col_valid_s && !tmo_hit_s &&
                        ((state_r == ST_WAIT_COL) ||
                         (((state_r == ST_SETTLE) || (state_r == ST_HOLD)) && (col_idx_s != col_r)));

  matrix_frame_decode u_decode (
    .frame (frame_buf_r),
    .seg   (seg_dec_s),
    .error (err_dec_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_WAIT_COL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a timeout abandons whatever was in progress
  always_comb begin
    state_nxt_s = state_r;
    if (tmo_hit_s) begin
      state_nxt_s = ST_WAIT_COL;
    end else begin
      case (state_r)
        ST_WAIT_COL: state_nxt_s = col_valid_s ? ST_SETTLE : ST_WAIT_COL;
        ST_SETTLE: begin
          if (!col_valid_s)      state_nxt_s = ST_WAIT_COL;
          else if (capture_s)    state_nxt_s = frame_done_s ? ST_EMIT : ST_HOLD;
          else                   state_nxt_s = ST_SETTLE;
        end
        ST_HOLD: begin
          if (!col_valid_s)             state_nxt_s = ST_WAIT_COL;
          else if (col_idx_s != col_r)  state_nxt_s = ST_SETTLE;
          else                          state_nxt_s = ST_HOLD;
        end
        ST_EMIT:  state_nxt_s = ST_HOLD;
        default:  state_nxt_s = ST_WAIT_COL;
      endcase
    end
  end

  // Output logic: outputs change only on EMIT, stale also on timeout
  always_comb begin
    seg_nxt_s   = seg_r;
    fv_nxt_s    = 1'b0;
    err_nxt_s   = err_r;
    stale_nxt_s = stale_r;
    if (state_r == ST_EMIT) begin
      seg_nxt_s   = {1'b1, seg_dec_s};
      fv_nxt_s    = 1'b1;
      err_nxt_s   = err_dec_s;
      stale_nxt_s = 1'b0;
    end else if (tmo_hit_s) begin
      stale_nxt_s = 1'b1;
    end else begin
      stale_nxt_s = stale_r;
    end
  end

  // Capture datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_r        <= 2'd0;
      row_ref_r    <= 8'h00;
      settle_cnt_r <= '0;
      tmo_cnt_r    <= '0;
      frame_buf_r  <= '0;
      seen_r       <= 4'h0;
      seg_r        <= 8'hFF;
      fv_r         <= 1'b0;
      err_r        <= 1'b0;
      stale_r      <= 1'b1;
    end else begin
      seg_r   <= seg_nxt_s;
      fv_r    <= fv_nxt_s;
      err_r   <= err_nxt_s;
      stale_r <= stale_nxt_s;
      if (capture_s) begin
        frame_buf_r[col_r] <= row_ref_r;
      end
      if (tmo_hit_s || (state_r == ST_EMIT)) begin
        seen_r <= 4'h0;
      end else if (capture_s) begin
        seen_r <= seen_nxt_s;
      end
      if (capture_s) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != TIMEOUT_MAX) begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end
      // Any row movement while settling restarts the stability count
      if (restart_s) begin
        col_r        <= col_idx_s;
        row_ref_r    <= lit_s;
        settle_cnt_r <= '0;
      end else if ((state_r == ST_SETTLE) && (lit_s != row_ref_r)) begin
        row_ref_r    <= lit_s;
        settle_cnt_r <= '0;
      end else if (settle_cnt_r != SETTLE_LAST) begin
        settle_cnt_r <= settle_cnt_r + 1'b1;
      end
    end
  end

  assign mif.sevenseg_out = seg_r;
  assign mif.frame_valid  = fv_r;
  assign mif.frame_error  = err_r;
  assign mif.stale        = stale_r;

endmodule

// File: tb/tb_matrix_to_sevenseg.sv
// Directed bench for matrix_to_sevenseg: hand-built column patterns with
// hand-decoded segment bytes, glitch, timeout and mid-frame reset scenarios.
module tb_matrix_to_sevenseg;

  localparam int TIMEOUT = 20000;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   fv_cnt;
  int   fv_base;

  matrix_to_sevenseg_if mif ();

  matrix_to_sevenseg #(
    .SYNC_STAGES (2),
    .SETTLE      (4),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mif.frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic hold_col(input logic [3:0] col, input logic [7:0] rows, input int n);
    mif.io_col = col;
    mif.io_out = rows;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    hold_col(4'b1110, c0, 50);
    hold_col(4'b1101, c1, 50);
    hold_col(4'b1011, c2, 50);
    hold_col(4'b0111, c3, 50);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    fv_cnt       = 0;
    rst_n        = 1'b0;
    mif.io_col   = 4'hF;
    mif.io_out   = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("rst_seg",   32'(mif.sevenseg_out), 32'hFF);
    check_eq("rst_fv",    32'(mif.frame_valid),  32'h0);
    check_eq("rst_err",   32'(mif.frame_error),  32'h0);
    check_eq("rst_stale", 32'(mif.stale),        32'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Digit 1: only b and c lit in column 3
    fv_base = fv_cnt;
    scan(8'hFF, 8'hFF, 8'hFF, 8'hC9);
    check_eq("d1_fv",    32'(fv_cnt - fv_base),  32'd1);
    check_eq("d1_seg",   32'(mif.sevenseg_out),  32'hF9);
    check_eq("d1_err",   32'(mif.frame_error),   32'h0);
    check_eq("d1_stale", 32'(mif.stale),         32'h0);

    // Digit 8, two back-to-back scans
    fv_base = fv_cnt;
    scan(8'hC9, 8'hB6, 8'hB6, 8'hC9);
    scan(8'hC9, 8'hB6, 8'hB6, 8'hC9);
    check_eq("d8_fv",  32'(fv_cnt - fv_base), 32'd2);
    check_eq("d8_seg", 32'(mif.sevenseg_out), 32'h80);
    check_eq("d8_err", 32'(mif.frame_error),  32'h0);

    // Digit 0: g dark
    fv_base = fv_cnt;
    scan(8'hC9, 8'hBE, 8'hBE, 8'hC9);
    check_eq("d0_fv",  32'(fv_cnt - fv_base), 32'd1);
    check_eq("d0_seg", 32'(mif.sevenseg_out), 32'hC0);
    check_eq("d0_err", 32'(mif.frame_error),  32'h0);

    // Half of segment f lit
    scan(8'hFD, 8'hFF, 8'hFF, 8'hC9);
    check_eq("part_seg", 32'(mif.sevenseg_out), 32'hF9);
    check_eq("part_err", 32'(mif.frame_error),  32'h1);

    // Corner pixel (0,0) lit on top of an 8
    scan(8'hC8, 8'hB6, 8'hB6, 8'hC9);
    check_eq("corner_seg", 32'(mif.sevenseg_out), 32'h80);
    check_eq("corner_err", 32'(mif.frame_error),  32'h1);

    // Row 7 pixel lit in column 2
    scan(8'hC9, 8'hB6, 8'h36, 8'hC9);
    check_eq("row7_seg", 32'(mif.sevenseg_out), 32'h80);
    check_eq("row7_err", 32'(mif.frame_error),  32'h1);

    // Glitch to column 2 while column 1 settles; column 2 must not be captured
    fv_base = fv_cnt;
    hold_col(4'b1110, 8'hFF, 50);
    hold_col(4'b1101, 8'hFF, 2);
    hold_col(4'b1011, 8'h00, 2);
    hold_col(4'b1101, 8'hFF, 50);
    hold_col(4'b0111, 8'hC9, 50);
    check_eq("glitch_nofv", 32'(fv_cnt - fv_base), 32'd0);
    hold_col(4'b1011, 8'hFF, 50);
    check_eq("glitch_fv",  32'(fv_cnt - fv_base), 32'd1);
    check_eq("glitch_seg", 32'(mif.sevenseg_out), 32'hF9);
    check_eq("glitch_err", 32'(mif.frame_error),  32'h0);

    // Timeout after a partial frame
    fv_base = fv_cnt;
    hold_col(4'b1110, 8'hC9, 50);
    hold_col(4'b1101, 8'hB6, 50);
    hold_col(4'hF, 8'hFF, TIMEOUT - 100);
    check_eq("tmo_early_stale", 32'(mif.stale), 32'h0);
    hold_col(4'hF, 8'hFF, 105);
    check_eq("tmo_stale", 32'(mif.stale),         32'h1);
    check_eq("tmo_seg",   32'(mif.sevenseg_out),  32'hF9);
    check_eq("tmo_nofv",  32'(fv_cnt - fv_base),  32'd0);
    scan(8'hC9, 8'hB6, 8'hB6, 8'hC9);
    check_eq("tmo_fv",        32'(fv_cnt - fv_base), 32'd1);
    check_eq("tmo_after_seg", 32'(mif.sevenseg_out), 32'h80);
    check_eq("tmo_after_stale", 32'(mif.stale),      32'h0);

    // Reset after column 2 capture discards the partial frame
    hold_col(4'b1110, 8'hC9, 50);
    hold_col(4'b1101, 8'hBE, 50);
    hold_col(4'b1011, 8'hBE, 50);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_seg",   32'(mif.sevenseg_out), 32'hFF);
    check_eq("mrst_fv",    32'(mif.frame_valid),  32'h0);
    check_eq("mrst_err",   32'(mif.frame_error),  32'h0);
    check_eq("mrst_stale", 32'(mif.stale),        32'h1);
    rst_n = 1'b1;
    fv_base = fv_cnt;
    hold_col(4'b1011, 8'hBE, 50);
    hold_col(4'b0111, 8'hC9, 50);
    check_eq("mrst_nofv", 32'(fv_cnt - fv_base), 32'd0);
    scan(8'hC9, 8'hBE, 8'hBE, 8'hC9);
    check_eq("mrst_fv",    32'(fv_cnt - fv_base), 32'd1);
    check_eq("mrst_seg2",  32'(mif.sevenseg_out), 32'hC0);
    check_eq("mrst_err2",  32'(mif.frame_error),  32'h0);
    check_eq("mrst_stale2", 32'(mif.stale),       32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
